seg_mux_decoder: RTL and testbench

- Receive-side counterpart to the two-digit multiplexed seven-segment driver.
- Samples a time-multiplexed segment bus (seg + digit_select), waits for each digit slot to be stable, and decodes the segment patterns back to BCD.
- Reassembles the 0..99 value and publishes it with a one-cycle valid strobe.
- Used for on-board self-check of the display path and for readback in simulation benches.

---
 rtl/seg_mux_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_seg_mux_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_mux_decoder.sv
// seg_mux_decoder
//   Receive-side decoder for a two-digit multiplexed seven-segment bus.
//   Waits for each digit slot to be stable, decodes the segment pattern back
//   to BCD, and reassembles the 0..99 value once both slots have been seen.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   seg_in[6:0]      segment pattern {g,f,e,d,c,b,a}, active-high
//   digit_select_in  one-hot slot select: 01 = ones, 10 = tens, 00/11 = none
//   value            last complete reassembled value (tens*10 + ones)
//   value_valid      one-cycle pulse when value updates
//   ones / tens      last captured BCD digits
//   decode_err       one-cycle pulse when a captured pattern is not a digit
module seg_mux_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int VALUE_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         seg_in,
  input  logic [1:0]         digit_select_in,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic [3:0]         ones,
  output logic [3:0]         tens,
  output logic               decode_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_BOTH = 2'd0,
    HAVE_ONES = 2'd1,
    HAVE_TENS = 2'd2
  } state_t;

  // Returns {valid, digit}; anything outside the ten digit glyphs is invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return {1'b0, 4'd0};
    endcase
  endfunction

  // Shift-add multiply by ten, zero-extended to the output width.
  function automatic logic [VALUE_W-1:0] times_ten(input logic [3:0] d);
    logic [VALUE_W-1:0] w;
    w = {{(VALUE_W-4){1'b0}}, d};
    return (w << 3'd3) + (w << 3'd1);
  endfunction

  logic [8:0]         live_s;
  logic [8:0]         sample_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               capture_s;
  logic [4:0]         dec_s;
  logic               ones_ok_s, tens_ok_s, ones_bad_s, tens_bad_s;
  state_t             state_r, state_nxt_s;
  logic               publish_s;
  logic [3:0]         pub_ones_s, pub_tens_s;
  logic [VALUE_W-1:0] value_nxt_s;
  logic               ones_seen_nxt_s, tens_seen_nxt_s;
  logic               ones_seen_r, tens_seen_r;
  logic [VALUE_W-1:0] value_r;
  logic               value_valid_r, decode_err_r;
  logic [3:0]         ones_r, tens_r;

  assign live_s = {digit_select_in, seg_in};

  // Capture fires on the single edge where the counter would reach its ceiling.
  always_comb begin
    capture_s  = (live_s == sample_r) && (cnt_r == STABLE_M1);
    dec_s      = seg_decode(sample_r[6:0]);
    ones_ok_s  = capture_s && (sample_r[8:7] == 2'b01) &&  dec_s[4];
    tens_ok_s  = capture_s && (sample_r[8:7] == 2'b10) &&  dec_s[4];
    ones_bad_s = capture_s && (sample_r[8:7] == 2'b01) && !dec_s[4];
    tens_bad_s = capture_s && (sample_r[8:7] == 2'b10) && !dec_s[4];
  end

  // Input sample register and saturating stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_r <= 9'd0;
      cnt_r    <= '0;
    end else begin
      sample_r <= live_s;
      if (live_s != sample_r) begin
        cnt_r <= '0;
      end else if (cnt_r < STABLE_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Publish FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= WAIT_BOTH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Publish FSM next-state logic; an error on the held slot drops the pair.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_BOTH: begin
        if (ones_ok_s) begin
          state_nxt_s = HAVE_ONES;
        end else if (tens_ok_s) begin
          state_nxt_s = HAVE_TENS;
        end else begin
          state_nxt_s = WAIT_BOTH;
        end
      end
      HAVE_ONES: begin
        if (tens_ok_s || ones_bad_s) begin
          state_nxt_s = WAIT_BOTH;
        end else begin
          state_nxt_s = HAVE_ONES;
        end
      end
      HAVE_TENS: begin
        if (ones_ok_s || tens_bad_s) begin
          state_nxt_s = WAIT_BOTH;
        end else begin
          state_nxt_s = HAVE_TENS;
        end
      end
      default: state_nxt_s = WAIT_BOTH;
    endcase
  end

  // Publish FSM output logic: next digits, value and seen flags.
  always_comb begin
    case (state_r)
      HAVE_ONES: publish_s = tens_ok_s;
      HAVE_TENS: publish_s = ones_ok_s;
      default:   publish_s = 1'b0;
    endcase
    if (ones_ok_s) begin
      pub_ones_s = dec_s[3:0];
    end else begin
      pub_ones_s = ones_r;
    end
    if (tens_ok_s) begin
      pub_tens_s = dec_s[3:0];
    end else begin
      pub_tens_s = tens_r;
    end
    value_nxt_s = times_ten(pub_tens_s) + {{(VALUE_W-4){1'b0}}, pub_ones_s};
    if (publish_s || ones_bad_s) begin
      ones_seen_nxt_s = 1'b0;
    end else if (ones_ok_s) begin
      ones_seen_nxt_s = 1'b1;
    end else begin
      ones_seen_nxt_s = ones_seen_r;
    end
    if (publish_s || tens_bad_s) begin
      tens_seen_nxt_s = 1'b0;
    end else if (tens_ok_s) begin
      tens_seen_nxt_s = 1'b1;
    end else begin
      tens_seen_nxt_s = tens_seen_r;
    end
  end

  // Registered outputs, digits and seen flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_r        <= 4'd0;
      tens_r        <= 4'd0;
      value_r       <= '0;
      value_valid_r <= 1'b0;
      decode_err_r  <= 1'b0;
      ones_seen_r   <= 1'b0;
      tens_seen_r   <= 1'b0;
    end else begin
      ones_r        <= pub_ones_s;
      tens_r        <= pub_tens_s;
      value_valid_r <= publish_s;
      decode_err_r  <= ones_bad_s || tens_bad_s;
      ones_seen_r   <= ones_seen_nxt_s;
      tens_seen_r   <= tens_seen_nxt_s;
      if (publish_s) begin
        value_r <= value_nxt_s;
      end
    end
  end

  assign value       = value_r;
  assign value_valid = value_valid_r;
  assign ones        = ones_r;
  assign tens        = tens_r;
  assign decode_err  = decode_err_r;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Scoreboard bench for seg_mux_decoder with STABLE_CYCLES=4.
module tb_seg_mux_decoder;

  localparam int SC = 4;
  localparam int VW = 7;

  logic          clk;
  logic          rst;
  logic [6:0]    seg_in;
  logic [1:0]    digit_select_in;
  logic [VW-1:0] value;
  logic          value_valid;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic          decode_err;

  typedef struct packed {
    logic [6:0] value;
    logic [3:0] ones;
    logic [3:0] tens;
  } pub_t;

  pub_t       pub_q[$];
  logic [3:0] err_q[$];   // expected ones digit at the decode_err pulse

  int checks   = 0;
  int failures = 0;

  seg_mux_decoder #(.STABLE_CYCLES(SC), .VALUE_W(VW)) dut (
    .clk             (clk),
    .rst             (rst),
    .seg_in          (seg_in),
    .digit_select_in (digit_select_in),
    .value           (value),
    .value_valid     (value_valid),
    .ones            (ones),
    .tens            (tens),
    .decode_err      (decode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold one pattern for n rising edges, then step just past the last edge.
  task automatic drive(input logic [1:0] sel, input logic [6:0] seg, input int n);
    digit_select_in = sel;
    seg_in          = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_pub(input int v, input int o, input int t);
    pub_t p;
    p.value = 7'(v);
    p.ones  = 4'(o);
    p.tens  = 4'(t);
    pub_q.push_back(p);
  endtask

  // Monitor: every strobe must match the oldest expected item.
  always @(negedge clk) begin
    if (rst) begin
      if (value_valid) begin
        if (pub_q.size() == 0) begin
          chk("unexpected_value_valid", 1, 0);
        end else begin
          pub_t p;
          p = pub_q.pop_front();
          chk("pub_value", int'(value), int'(p.value));
          chk("pub_ones",  int'(ones),  int'(p.ones));
          chk("pub_tens",  int'(tens),  int'(p.tens));
        end
      end
      if (decode_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_decode_err", 1, 0);
        end else begin
          logic [3:0] e;
          e = err_q.pop_front();
          chk("err_ones_unchanged", int'(ones), int'(e));
        end
      end
    end
  end

  initial begin
    rst             = 1'b0;
    seg_in          = 7'h00;
    digit_select_in = 2'b00;
    #12;
    chk("reset_value",       int'(value),       0);
    chk("reset_ones",        int'(ones),        0);
    chk("reset_tens",        int'(tens),        0);
    chk("reset_value_valid", int'(value_valid), 0);
    chk("reset_decode_err",  int'(decode_err),  0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Pair capture: ones 2, tens 4 -> 42
    drive(2'b01, 7'h5B, SC + 1);
    exp_pub(42, 2, 4);
    drive(2'b10, 7'h66, SC + 1);

    // Glitch rejection: short ones '1' ignored, ones 3 + tens 0 -> 3
    drive(2'b01, 7'h06, SC - 1);
    drive(2'b01, 7'h4F, SC + 1);
    exp_pub(3, 3, 0);
    drive(2'b10, 7'h3F, SC + 1);

    // Invalid blank pattern on ones slot, then 9 and 7 -> 79
    err_q.push_back(4'd3);
    drive(2'b01, 7'h00, SC + 1);
    drive(2'b01, 7'h6F, SC + 1);
    exp_pub(79, 9, 7);
    drive(2'b10, 7'h07, SC + 1);

    // Latest-wins: ones 1 then 8, tens 5 -> 58
    drive(2'b01, 7'h06, SC + 1);
    drive(2'b01, 7'h7F, SC + 1);
    exp_pub(58, 8, 5);
    drive(2'b10, 7'h6D, SC + 1);

    // Ignored slot, then a long hold captures exactly once
    drive(2'b11, 7'h7F, 20);
    chk("sel11_ones_kept", int'(ones), 8);
    drive(2'b01, 7'h3F, 30);
    chk("long_hold_ones", int'(ones), 0);
    chk("long_hold_value_kept", int'(value), 58);

    // Async reset mid-cycle discards the partial pair
    drive(2'b01, 7'h6F, SC + 1);
    chk("pre_reset_ones", int'(ones), 9);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_value", int'(value), 0);
    chk("async_rst_ones",  int'(ones),  0);
    chk("async_rst_tens",  int'(tens),  0);
    repeat (2) @(posedge clk);
    digit_select_in = 2'b10;
    seg_in          = 7'h06;
    @(negedge clk);
    rst = 1'b1;
    drive(2'b10, 7'h06, SC + 1);
    chk("after_reset_tens", int'(tens), 1);
    exp_pub(12, 2, 1);
    drive(2'b01, 7'h5B, SC + 1);
    drive(2'b00, 7'h00, 4);

    chk("pub_queue_drained", pub_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
